// File: rtl/demux_1to2_reg_if.sv
// Handshake bundle for the registered 1-to-2 demultiplexer: one input
// stream, two output channels, and the per-channel debug counters.
interface demux_1to2_reg_if #(
  parameter int WIDTH = 4,
  parameter int CW    = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y0_data;
  logic             y0_valid;
  logic             y0_ready;
  logic [WIDTH-1:0] y1_data;
  logic             y1_valid;
  logic             y1_ready;
  logic [CW-1:0]    cnt0;
  logic [CW-1:0]    cnt1;

  // Source/consumer side: drives the input word and the output readies.
  modport master (
    output in_data, in_sel, in_valid, y0_ready, y1_ready,
    input  in_ready, y0_data, y0_valid, y1_data, y1_valid, cnt0, cnt1
  );

  // Demux side.
  modport slave (
    input  in_data, in_sel, in_valid, y0_ready, y1_ready,
    output in_ready, y0_data, y0_valid, y1_data, y1_valid, cnt0, cnt1
  );
endinterface

// File: rtl/demux_1to2_reg.sv
// Registered 1-to-2 demultiplexer. Each output channel has a one-word
// holding slot; the input is accepted when the selected slot is empty or
// is being drained in the same cycle, so a streaming channel runs at one
// word per cycle without bubbles.
//
// slot state | meaning
// EMPTY      | yn_valid=0, slot can take a word
// FULL       | yn_valid=1, word waiting for the channel consumer
module demux_1to2_reg #(
  parameter int WIDTH = 4,
  parameter int CW    = 8
) (
  input logic              clk,
  input logic              rst,
  demux_1to2_reg_if.slave  bus
);

  logic [WIDTH-1:0] y0_data_q, y0_data_d;
  logic [WIDTH-1:0] y1_data_q, y1_data_d;
  logic             y0_valid_q, y0_valid_d;
  logic             y1_valid_q, y1_valid_d;
  logic [CW-1:0]    cnt0_q, cnt0_d;
  logic [CW-1:0]    cnt1_q, cnt1_d;
  logic             free0, free1;
  logic             in_ready;
  logic             acc0, acc1;

  // Acceptance decode and next-state for both slots and counters.
  always_comb begin
    free0    = ~y0_valid_q | bus.y0_ready;
    free1    = ~y1_valid_q | bus.y1_ready;
    // in_ready deliberately ignores in_valid so the source can look ahead.
    in_ready = bus.in_sel ? free1 : free0;
    acc0     = bus.in_valid & in_ready & ~bus.in_sel;
    acc1     = bus.in_valid & in_ready &  bus.in_sel;

    y0_valid_d = y0_valid_q;
    y0_data_d  = y0_data_q;
    if (acc0) begin
      // Covers the pop-and-push case: a draining FULL slot reloads at once.
      y0_valid_d = 1'b1;
      y0_data_d  = bus.in_data;
    end else if (y0_valid_q & bus.y0_ready) begin
      y0_valid_d = 1'b0;
    end

    y1_valid_d = y1_valid_q;
    y1_data_d  = y1_data_q;
    if (acc1) begin
      y1_valid_d = 1'b1;
      y1_data_d  = bus.in_data;
    end else if (y1_valid_q & bus.y1_ready) begin
      y1_valid_d = 1'b0;
    end

    cnt0_d = cnt0_q + {{(CW-1){1'b0}}, acc0};
    cnt1_d = cnt1_q + {{(CW-1){1'b0}}, acc1};
  end

  // Slot and counter registers; reset discards any held word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y0_valid_q <= 1'b0;
      y1_valid_q <= 1'b0;
      y0_data_q  <= '0;
      y1_data_q  <= '0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      y0_valid_q <= y0_valid_d;
      y1_valid_q <= y1_valid_d;
      y0_data_q  <= y0_data_d;
      y1_data_q  <= y1_data_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.y0_data  = y0_data_q;
  assign bus.y0_valid = y0_valid_q;
  assign bus.y1_data  = y1_data_q;
  assign bus.y1_valid = y1_valid_q;
  assign bus.cnt0     = cnt0_q;
  assign bus.cnt1     = cnt1_q;

endmodule

// File: tb/tb_demux_1to2_reg.sv
// Bench for demux_1to2_reg: directed scenarios plus a randomized run,
// with expected words held per channel in scoreboard queues.
module tb_demux_1to2_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux_1to2_reg_if #(.WIDTH(4), .CW(8)) b ();
  demux_1to2_reg_if #(.WIDTH(4), .CW(2)) b2 ();

  demux_1to2_reg #(.WIDTH(4), .CW(8)) dut  (.clk(clk), .rst(rst), .bus(b));
  demux_1to2_reg #(.WIDTH(4), .CW(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  int passed = 0;
  int total  = 0;

  logic [3:0] q0[$];
  logic [3:0] q1[$];
  int         mc0 = 0;
  int         mc1 = 0;
  logic       last_acc = 1'b0;

  // Advance one clock on the main DUT while updating the scoreboard from
  // the bench's own view of slot occupancy and handshakes.
  task automatic tick_sb();
    logic f0, f1, rdy;
    f0  = (q0.size() == 0) || b.y0_ready;
    f1  = (q1.size() == 0) || b.y1_ready;
    rdy = b.in_sel ? f1 : f0;
    if (q0.size() != 0 && b.y0_ready) void'(q0.pop_front());
    if (q1.size() != 0 && b.y1_ready) void'(q1.pop_front());
    last_acc = b.in_valid && rdy;
    if (last_acc) begin
      if (b.in_sel) begin q1.push_back(b.in_data); mc1++; end
      else          begin q0.push_back(b.in_data); mc0++; end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete(); q1.delete();
    mc0 = 0; mc1 = 0;
  endtask

  task automatic test_reset();
    b.in_valid = 1'b0; b.in_sel = 1'b0; b.in_data = 4'h0;
    b.y0_ready = 1'b0; b.y1_ready = 1'b0;
    b2.in_valid = 1'b0; b2.in_sel = 1'b0; b2.in_data = 4'h0;
    b2.y0_ready = 1'b0; b2.y1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    b.in_data = 4'hC; b.in_valid = 1'b1;
    tick_sb();
    b.in_valid = 1'b0;
    total++;
    if (b.y0_valid !== 1'b1) $display("FAIL reset_prefill y0_valid got %b want 1", b.y0_valid);
    else passed++;
    rst = 1'b1;
    #1;
    q0.delete(); q1.delete(); mc0 = 0; mc1 = 0;
    total++;
    if (b.y0_valid !== 1'b0 || b.y1_valid !== 1'b0)
      $display("FAIL reset_valid got y0=%b y1=%b want 0 0", b.y0_valid, b.y1_valid);
    else passed++;
    total++;
    if (b.cnt0 !== 8'd0 || b.cnt1 !== 8'd0 || b.y0_data !== 4'h0)
      $display("FAIL reset_cnt_data got cnt0=%0d cnt1=%0d y0_data=%h want 0 0 0", b.cnt0, b.cnt1, b.y0_data);
    else passed++;
    total++;
    if (b.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", b.in_ready);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic_route();
    b.y0_ready = 1'b1; b.y1_ready = 1'b1;
    b.in_data = 4'hA; b.in_sel = 1'b0; b.in_valid = 1'b1;
    #1;
    total++;
    if (b.in_ready !== 1'b1) $display("FAIL basic_in_ready got %b want 1", b.in_ready);
    else passed++;
    tick_sb();
    total++;
    if (b.y0_valid !== 1'b1 || b.y0_data !== 4'hA || b.y1_valid !== 1'b0 || b.cnt0 !== 8'd1)
      $display("FAIL basic_ch0 got v0=%b d0=%h v1=%b cnt0=%0d want 1 a 0 1",
               b.y0_valid, b.y0_data, b.y1_valid, b.cnt0);
    else passed++;
    b.in_data = 4'h5; b.in_sel = 1'b1;
    tick_sb();
    b.in_valid = 1'b0;
    total++;
    if (b.y1_valid !== 1'b1 || b.y1_data !== 4'h5 || b.cnt1 !== 8'd1 || b.y0_valid !== 1'b0)
      $display("FAIL basic_ch1 got v1=%b d1=%h cnt1=%0d v0=%b want 1 5 1 0",
               b.y1_valid, b.y1_data, b.cnt1, b.y0_valid);
    else passed++;
    tick_sb();
  endtask

  task automatic test_backpressure();
    b.y0_ready = 1'b0;
    b.in_data = 4'h3; b.in_sel = 1'b0; b.in_valid = 1'b1;
    tick_sb();
    b.in_data = 4'h7;
    #1;
    total++;
    if (b.in_ready !== 1'b0) $display("FAIL bp_in_ready_stalled got %b want 0", b.in_ready);
    else passed++;
    tick_sb();
    tick_sb();
    total++;
    if (b.y0_valid !== 1'b1 || b.y0_data !== 4'h3 || q0.size() != 1 || q0[0] !== 4'h3)
      $display("FAIL bp_hold got v0=%b d0=%h want 1 3", b.y0_valid, b.y0_data);
    else passed++;
    b.y0_ready = 1'b1;
    #1;
    total++;
    if (b.in_ready !== 1'b1) $display("FAIL bp_in_ready_drain got %b want 1", b.in_ready);
    else passed++;
    tick_sb();
    b.in_valid = 1'b0; b.y0_ready = 1'b0;
    total++;
    if (b.y0_valid !== 1'b1 || b.y0_data !== 4'h7 || b.cnt0 !== 8'(mc0))
      $display("FAIL bp_no_bubble got v0=%b d0=%h cnt0=%0d want 1 7 %0d",
               b.y0_valid, b.y0_data, b.cnt0, mc0);
    else passed++;
  endtask

  task automatic test_independence();
    b.y0_ready = 1'b0; b.y1_ready = 1'b0;
    b.in_data = 4'h9; b.in_sel = 1'b1; b.in_valid = 1'b1;
    #1;
    total++;
    if (b.in_ready !== 1'b1) $display("FAIL indep_in_ready got %b want 1", b.in_ready);
    else passed++;
    tick_sb();
    b.in_valid = 1'b0;
    total++;
    if (b.y1_valid !== 1'b1 || b.y1_data !== 4'h9 || b.y0_valid !== 1'b1 || b.y0_data !== 4'h7)
      $display("FAIL indep_route got v1=%b d1=%h v0=%b d0=%h want 1 9 1 7",
               b.y1_valid, b.y1_data, b.y0_valid, b.y0_data);
    else passed++;
    b.in_sel = 1'b0;
    #1;
    total++;
    if (b.in_ready !== 1'b0) $display("FAIL indep_sel_reeval got %b want 0", b.in_ready);
    else passed++;
    b.y0_ready = 1'b1; b.y1_ready = 1'b1;
    tick_sb();
    total++;
    if (b.y0_valid !== 1'b0 || b.y1_valid !== 1'b0)
      $display("FAIL indep_drain got v0=%b v1=%b want 0 0", b.y0_valid, b.y1_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] w;
    do_reset();
    b.y0_ready = 1'b1; b.y1_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w = 4'(i);
      b.in_data = w; b.in_sel = w[0]; b.in_valid = 1'b1;
      #1;
      total++;
      if (b.in_ready !== 1'b1) $display("FAIL b2b_in_ready word %0d got %b want 1", i, b.in_ready);
      else passed++;
      tick_sb();
      total++;
      if (w[0] == 1'b0) begin
        if (b.y0_valid !== 1'b1 || q0.size() != 1 || b.y0_data !== q0[0] || b.y0_data !== w)
          $display("FAIL b2b_ch0 word %0d got v=%b d=%h want 1 %h", i, b.y0_valid, b.y0_data, w);
        else passed++;
      end else begin
        if (b.y1_valid !== 1'b1 || q1.size() != 1 || b.y1_data !== q1[0] || b.y1_data !== w)
          $display("FAIL b2b_ch1 word %0d got v=%b d=%h want 1 %h", i, b.y1_valid, b.y1_data, w);
        else passed++;
      end
    end
    b.in_valid = 1'b0;
    total++;
    if (b.cnt0 !== 8'd8 || b.cnt1 !== 8'd8)
      $display("FAIL b2b_counts got cnt0=%0d cnt1=%0d want 8 8", b.cnt0, b.cnt1);
    else passed++;
    tick_sb();
  endtask

  task automatic test_wrap();
    b2.y0_ready = 1'b1; b2.y1_ready = 1'b1;
    b2.in_sel = 1'b1; b2.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b2.in_data = 4'(i + 2);
      @(posedge clk); #1;
      if (i == 3) begin
        total++;
        if (b2.cnt1 !== 2'd0) $display("FAIL wrap_at_4 got cnt1=%0d want 0", b2.cnt1);
        else passed++;
      end
    end
    b2.in_valid = 1'b0;
    total++;
    if (b2.cnt1 !== 2'd1 || b2.cnt0 !== 2'd0 || b2.y1_data !== 4'h6)
      $display("FAIL wrap_final got cnt1=%0d cnt0=%0d d1=%h want 1 0 6", b2.cnt1, b2.cnt0, b2.y1_data);
    else passed++;
  endtask

  task automatic test_random();
    logic pending;
    logic exp_rdy;
    int   errs = 0;
    b.in_valid = 1'b0;
    last_acc = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      pending = b.in_valid && !last_acc;
      if (!pending) begin
        b.in_valid = ($urandom_range(0, 3) != 0);
        b.in_data  = 4'($urandom);
        b.in_sel   = 1'($urandom);
      end else if ($urandom_range(0, 3) == 0) begin
        b.in_sel = ~b.in_sel;
      end
      b.y0_ready = ($urandom_range(0, 2) != 0);
      b.y1_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = b.in_sel ? ((q1.size() == 0) || b.y1_ready) : ((q0.size() == 0) || b.y0_ready);
      total++;
      if (b.in_ready !== exp_rdy) begin
        if (errs < 10) $display("FAIL rand_in_ready cycle %0d got %b want %b", i, b.in_ready, exp_rdy);
        errs++;
      end else passed++;
      tick_sb();
      total++;
      if (b.y0_valid !== (q0.size() != 0) || b.y1_valid !== (q1.size() != 0) ||
          (q0.size() != 0 && b.y0_data !== q0[0]) || (q1.size() != 0 && b.y1_data !== q1[0]) ||
          b.cnt0 !== 8'(mc0) || b.cnt1 !== 8'(mc1)) begin
        if (errs < 10)
          $display("FAIL rand_outputs cycle %0d got v0=%b d0=%h v1=%b d1=%h c0=%0d c1=%0d want v0=%0d v1=%0d c0=%0d c1=%0d",
                   i, b.y0_valid, b.y0_data, b.y1_valid, b.y1_data, b.cnt0, b.cnt1,
                   q0.size(), q1.size(), mc0 % 256, mc1 % 256);
        errs++;
      end else passed++;
    end
    b.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_route();
    test_backpressure();
    test_independence();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
